// File: rtl/random_arbiter.sv
// random_arbiter: round-robin arbiter that hands out samples of a free-running random
// generator. A grant delivers the current random value and then enforces an N-cycle
// cooldown so the generator fully refreshes before the next sample is handed out. A
// stall detector withholds grants while the generator output stops changing.
//
// Ports:
//   clk   - system clock, rising edge
//   rst   - asynchronous active-low reset
//   rnd   - current random generator output (N bits), sampled every clock
//   req   - per-requester level request (NREQ bits), held until acked
//   ack   - one-hot, single-cycle grant pulse (NREQ bits)
//   data  - random value captured on the grant edge, held until the next grant
//   busy  - high during cooldown (HOLD state)
//   stuck - registered generator-stalled flag
module random_arbiter #(
    parameter int unsigned N    = 8,
    parameter int unsigned NREQ = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    rnd,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] ack,
    output logic [N-1:0]    data,
    output logic            busy,
    output logic            stuck
);

    localparam int unsigned PtrW  = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned CntW  = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned ScntW = $clog2(2 * N) + 1;

    localparam logic [ScntW-1:0] StallLimit = ScntW'(2 * N);
    localparam logic [CntW-1:0]  CntLoad    = CntW'(N - 1);
    localparam logic [PtrW-1:0]  PtrLast    = PtrW'(NREQ - 1);

    typedef enum logic [0:0] {
        StIdle,
        StHold
    } state_e;

    state_e            state_q, state_d;
    logic [PtrW-1:0]   ptr_q, ptr_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [NREQ-1:0]   ack_q, ack_d;
    logic [N-1:0]      data_q, data_d;
    logic [N-1:0]      prev_q, prev_d;
    logic [ScntW-1:0]  scnt_q, scnt_d;
    logic              stuck_q, stuck_d;

    logic              found;
    logic [PtrW-1:0]   grant_idx;
    logic [PtrW-1:0]   idx_w;
    int unsigned       idx;

    // Circular search for the first pending request at or after ptr_q.
    always_comb begin
        found     = 1'b0;
        grant_idx = '0;
        idx       = 0;
        idx_w     = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            idx = int'(ptr_q) + i;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            idx_w = PtrW'(idx);
            if (!found && req[idx_w]) begin
                found     = 1'b1;
                grant_idx = idx_w;
            end
        end
    end

    // Stall detector: counts consecutive edges on which the generator did not change.
    always_comb begin
        prev_d  = rnd;
        scnt_d  = scnt_q;
        stuck_d = stuck_q;
        if (rnd != prev_q) begin
            scnt_d  = '0;
            stuck_d = 1'b0;
        end else begin
            if (scnt_q != StallLimit) begin
                scnt_d = scnt_q + 1'b1;
            end
            if (scnt_d == StallLimit) begin
                stuck_d = 1'b1;
            end
        end
    end

    // Grant / cooldown FSM.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        ack_d   = '0;
        data_d  = data_q;
        unique case (state_q)
            StIdle: begin
                if (!stuck_q && found) begin
                    ack_d[grant_idx] = 1'b1;
                    data_d           = rnd;
                    ptr_d            = (grant_idx == PtrLast) ? '0 : grant_idx + 1'b1;
                    cnt_d            = CntLoad;
                    state_d          = StHold;
                end
            end
            StHold: begin
                // Stuck rising here does not cut the cooldown short.
                if (cnt_q == '0) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            cnt_q   <= '0;
            ack_q   <= '0;
            data_q  <= '0;
            prev_q  <= '0;
            scnt_q  <= '0;
            stuck_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            ack_q   <= ack_d;
            data_q  <= data_d;
            prev_q  <= prev_d;
            scnt_q  <= scnt_d;
            stuck_q <= stuck_d;
        end
    end

    assign ack   = ack_q;
    assign data  = data_q;
    assign busy  = (state_q == StHold);
    assign stuck = stuck_q;

endmodule

// File: tb/tb_random_arbiter.sv
// Directed bench for random_arbiter with N=3, NREQ=4: a table of single-grant
// vectors followed by hand-written multi-cycle sequences (reset mid-cooldown,
// round-robin spacing, generator stall, dropped request).
module tb_random_arbiter;

    logic       clk;
    logic       rst;
    logic [2:0] rnd;
    logic [3:0] req;
    logic [3:0] ack;
    logic [2:0] data;
    logic       busy;
    logic       stuck;

    int n_vec;
    int n_err;
    bit auto_rnd;

    random_arbiter #(
        .N    (3),
        .NREQ (4)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .rnd   (rnd),
        .req   (req),
        .ack   (ack),
        .data  (data),
        .busy  (busy),
        .stuck (stuck)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] req;
        logic [2:0] rnd;
        logic [3:0] exp_ack;
        logic [2:0] exp_data;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance past the next rising edge and settle; optionally step the generator.
    task automatic tick();
        @(posedge clk);
        #1;
        if (auto_rnd) rnd = rnd + 3'd1;
    endtask

    initial begin
        logic [2:0] g_rnd;
        logic       granted;

        n_vec    = 0;
        n_err    = 0;
        auto_rnd = 1'b1;
        rst      = 1'b0;
        rnd      = 3'b000;
        req      = 4'b0000;

        // ptr carries over from vector to vector, starting at 0 after reset.
        vecs[0] = '{req: 4'b0100, rnd: 3'b110, exp_ack: 4'b0100, exp_data: 3'b110};
        vecs[1] = '{req: 4'b0101, rnd: 3'b011, exp_ack: 4'b0001, exp_data: 3'b011};
        vecs[2] = '{req: 4'b0101, rnd: 3'b001, exp_ack: 4'b0100, exp_data: 3'b001};
        vecs[3] = '{req: 4'b1000, rnd: 3'b111, exp_ack: 4'b1000, exp_data: 3'b111};
        vecs[4] = '{req: 4'b1010, rnd: 3'b010, exp_ack: 4'b0010, exp_data: 3'b010};
        vecs[5] = '{req: 4'b0011, rnd: 3'b100, exp_ack: 4'b0001, exp_data: 3'b100};
        vecs[6] = '{req: 4'b0000, rnd: 3'b011, exp_ack: 4'b0000, exp_data: 3'b100};
        vecs[7] = '{req: 4'b1111, rnd: 3'b101, exp_ack: 4'b0010, exp_data: 3'b101};

        #12;
        check("reset_ack", 32'(ack), 32'h0);
        check("reset_data", 32'(data), 32'h0);
        check("reset_busy", 32'(busy), 32'h0);
        check("reset_stuck", 32'(stuck), 32'h0);
        rst = 1'b1;

        // Table: one grant attempt per vector followed by a full cooldown.
        for (int v = 0; v < 8; v++) begin
            req = vecs[v].req;
            rnd = vecs[v].rnd;
            granted = (vecs[v].exp_ack != 4'b0000);
            tick();
            check($sformatf("vec%0d_ack", v), 32'(ack), 32'(vecs[v].exp_ack));
            check($sformatf("vec%0d_data", v), 32'(data), 32'(vecs[v].exp_data));
            check($sformatf("vec%0d_busy", v), 32'(busy), 32'(granted));
            req = 4'b0000;
            for (int k = 0; k < 3; k++) begin
                tick();
                check($sformatf("vec%0d_cool%0d_ack", v, k), 32'(ack), 32'h0);
                check($sformatf("vec%0d_cool%0d_busy", v, k), 32'(busy),
                      32'(granted && (k < 2)));
                check($sformatf("vec%0d_cool%0d_data", v, k), 32'(data),
                      32'(vecs[v].exp_data));
            end
        end

        // Reset asserted two cycles into a cooldown takes effect immediately.
        req = 4'b0100;
        tick();
        check("rst_mid_grant_ack", 32'(ack), 32'h4);
        req = 4'b0000;
        tick();
        tick();
        check("rst_mid_busy_before", 32'(busy), 32'h1);
        rst = 1'b0;
        #1;
        check("rst_mid_ack", 32'(ack), 32'h0);
        check("rst_mid_data", 32'(data), 32'h0);
        check("rst_mid_busy", 32'(busy), 32'h0);
        check("rst_mid_stuck", 32'(stuck), 32'h0);
        req   = 4'b0001;
        rst   = 1'b1;
        g_rnd = rnd;
        tick();
        check("post_rst_ack", 32'(ack), 32'h1);
        check("post_rst_data", 32'(data), 32'(g_rnd));
        req = 4'b0000;
        for (int k = 0; k < 3; k++) tick();

        // Round-robin with all requests held: pulses every 4 cycles.
        rst = 1'b0;
        #1;
        rst = 1'b1;
        req = 4'b1111;
        for (int k = 0; k < 17; k++) begin
            tick();
            check($sformatf("rr%0d_ack", k), 32'(ack),
                  (k % 4 == 0) ? (32'h1 << ((k / 4) % 4)) : 32'h0);
            check($sformatf("rr%0d_busy", k), 32'(busy), 32'(k % 4 != 3));
        end
        req = 4'b0000;
        for (int k = 0; k < 3; k++) tick();

        // Generator stall: hold rnd constant until stuck, then release it.
        auto_rnd = 1'b0;
        rnd = 3'b000;
        tick();
        rnd = 3'b101;
        for (int t = 1; t <= 7; t++) begin
            tick();
            check($sformatf("stall_t%0d_stuck", t), 32'(stuck), 32'(t == 7));
        end
        req = 4'b0010;
        for (int t = 0; t < 4; t++) begin
            tick();
            check($sformatf("stalled%0d_ack", t), 32'(ack), 32'h0);
            check($sformatf("stalled%0d_stuck", t), 32'(stuck), 32'h1);
        end
        rnd = 3'b010;
        tick();
        check("unstall_stuck", 32'(stuck), 32'h0);
        check("unstall_ack", 32'(ack), 32'h0);
        tick();
        check("unstall_grant_ack", 32'(ack), 32'h2);
        check("unstall_grant_data", 32'(data), 32'h2);
        req = 4'b0000;
        auto_rnd = 1'b1;
        for (int k = 0; k < 3; k++) tick();

        // Dropped request: req[1] released during cooldown never gets acked.
        req = 4'b0011;
        tick();
        check("drop_grant_ack", 32'(ack), 32'h1);
        req = 4'b0000;
        for (int k = 0; k < 6; k++) begin
            tick();
            check($sformatf("drop%0d_ack", k), 32'(ack), 32'h0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/random_arbiter.md
RANDOM_ARBITER -- requirements
Module: random_arbiter

Interface
REQ-001 Parameter N, default 8: width of the random sample; matches the N of the random generator it serves.
REQ-002 Parameter NREQ, default 4: number of requesters, legal range 2..8.
REQ-003 clk  input  1  system clock; all state updates on the rising edge.
REQ-004 rst  input  1  one clock; reset is asynchronous and active-low (rst low = reset asserted).
REQ-005 rnd  input  N  current output of the free-running random generator, sampled every clock.
REQ-006 req  input  NREQ  per-requester request, level; the requester holds it high until its ack.
REQ-007 ack  output  NREQ  one-hot grant pulse, exactly one cycle wide.
REQ-008 data  output  N  random value delivered with ack; held until the next grant.
REQ-009 busy  output  1  high while the arbiter is in cooldown.
REQ-010 stuck  output  1  generator-stalled flag.

Function
REQ-011 The FSM SHALL have two states: IDLE and HOLD.
REQ-012 In IDLE, with stuck=0 and req!=0, the arbiter SHALL select the first set req bit at or after index ptr, searching upward and wrapping from NREQ-1 to 0.
REQ-013 On that edge it SHALL perform all of the following:
- data<=rnd;
- ack<=one-hot of the selected index g;
- ptr<=(g+1) mod NREQ;
- cnt<=N-1;
- state<=HOLD.
REQ-014 ack SHALL return to 0 on the following edge, giving a single-cycle pulse; grant latency is one cycle from the sampling edge.
REQ-015 In HOLD, cnt SHALL decrement each edge; on the edge where cnt==0, state SHALL return to IDLE.
REQ-016 Minimum spacing between consecutive ack pulses SHALL be N+1 cycles, so that every granted sample is fully refreshed by the generator.
REQ-017 busy SHALL equal (state==HOLD).
REQ-018 In HOLD, req changes SHALL be ignored. A request dropped before the return to IDLE SHALL receive no ack.
REQ-019 The arbiter SHALL never raise ack[i] unless req[i] was high on the grant edge, and SHALL never raise more than one ack bit.
REQ-020 The block SHALL keep register prev<=rnd every edge and a saturating counter scnt of width clog2(2N)+1 that behaves as follows:
- scnt SHALL increment when rnd==prev;
- scnt SHALL clear to 0 when rnd!=prev.
REQ-021 stuck SHALL be registered, set on the edge where scnt reaches 2N, and cleared on the first edge where rnd!=prev.
REQ-022 While stuck=1, IDLE SHALL issue no grants. Pending requests SHALL stay pending and SHALL be served in round-robin order after stuck clears.
REQ-023 If stuck rises during HOLD, the cooldown SHALL complete normally.
REQ-024 ptr width SHALL be clog2(NREQ). Wrap SHALL be explicit at NREQ-1, which covers non-power-of-two NREQ.

Reset
REQ-025 Asserting rst low, at any time including mid-HOLD, SHALL immediately force:
- state=IDLE;
- ack=0, data=0, busy=0, stuck=0;
- ptr=0, cnt=0, prev=0, scnt=0.
REQ-026 After rst rises, the first grant SHALL be possible on the first clock edge.

Verification
N=3, NREQ=4, rnd driven by the random generator unless stated otherwise.
REQ-027 Reset mid-HOLD: rst low 2 cycles after a grant -> ack=0000, data=000, busy=0 at once. Then rst high with req=0001 -> ack=0001 on the first edge.
REQ-028 Round-robin: req=1111 held -> ack sequence 0001, 0010, 0100, 1000, 0001, with consecutive pulses exactly 4 cycles apart and busy high 3 cycles after each.
REQ-029 Wrap-around, in order:
- ptr=0, req=0100 -> ack=0100 and ptr=3;
- then req=0101 -> ack=0001, not 0100;
- then ptr=1.
REQ-030 Data capture: rnd=3'b110 on the grant edge -> data=110 with ack. data stays 110 until the next grant, whatever rnd does.
REQ-031 Stall:
- rnd forced to 3'b101 -> stuck=1 on the edge where scnt reaches 6;
- req=0010 issued while stuck=1 -> no ack;
- rnd changes -> stuck=0 on the next edge, then ack=0010 one edge later.
REQ-032 Dropped request: req=0011 -> ack=0001. req[1] is dropped during HOLD -> no ack is issued after cooldown.
